// File: rtl/ro_scheduler_if.sv
// rtl/ro_scheduler_if.sv - readout scheduler signal bundle
//
// Groups the run request, mask, shared readout line and all scheduler
// outputs into one bundle.
//   master : drives en, ch_mask, din; observes slot, frame and capture outputs
//   slave  : the scheduler itself
interface ro_scheduler_if #(
    parameter int NCH = 17,
    parameter int CW  = 5
);
    logic           en;
    logic [NCH-1:0] ch_mask;
    logic           din;
    logic [NCH-1:0] grant;
    logic [CW-1:0]  slot_ch;
    logic           slot_valid;
    logic [NCH-1:0] gray_cnt;
    logic           frame_sync;
    logic           dout;
    logic [CW-1:0]  dout_ch;
    logic           dout_valid;
    logic           busy;

    modport master (
        output en, ch_mask, din,
        input  grant, slot_ch, slot_valid, gray_cnt, frame_sync,
        input  dout, dout_ch, dout_valid, busy
    );

    modport slave (
        input  en, ch_mask, din,
        output grant, slot_ch, slot_valid, gray_cnt, frame_sync,
        output dout, dout_ch, dout_valid, busy
    );
endinterface

// File: rtl/ro_scheduler.sv
// rtl/ro_scheduler.sv - Gray-code time-division readout scheduler
//
// Each clock in RUN/DRAIN one channel owns the shared readout line: the
// channel whose Gray bit toggles on that counter step. Channel 0 gets every
// other slot, each higher channel half the rate of the one below.
//   clk_ext    : single clock, rising edge
//   rstb       : asynchronous active-low reset
//   bus.en     : level run request
//   bus.ch_mask: per-channel slot enable
//   bus.din    : shared readout line
//   bus.grant/slot_ch/slot_valid/gray_cnt : current slot
//   bus.frame_sync : preamble marker
//   bus.dout/dout_ch/dout_valid : din captured one cycle after each slot
//   bus.busy   : not IDLE
module ro_scheduler #(
    parameter int NCH     = 17,
    parameter int PRE_LEN = 4,
    parameter int CW      = 5
) (
    input  logic          clk_ext,
    input  logic          rstb,
    ro_scheduler_if.slave bus
);
    localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PRE, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] b_q, b_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [NCH-1:0] gray_q, gray_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic [CW-1:0]  slot_ch_q, slot_ch_d;
    logic           slot_valid_q, slot_valid_d;
    logic           wrap_q, wrap_d;
    logic           dout_q, dout_d;
    logic [CW-1:0]  dout_ch_q, dout_ch_d;
    logic           dout_valid_q, dout_valid_d;

    logic [NCH-1:0] b_inc;
    logic [NCH-1:0] toggle;
    logic [CW-1:0]  toggle_idx;
    logic           issue;

    function automatic logic [NCH-1:0] to_gray(input logic [NCH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            b_q          <= '0;
            pre_q        <= '0;
            gray_q       <= '0;
            grant_q      <= '0;
            slot_ch_q    <= '0;
            slot_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            dout_q       <= 1'b0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            pre_q        <= pre_d;
            gray_q       <= gray_d;
            grant_q      <= grant_d;
            slot_ch_q    <= slot_ch_d;
            slot_valid_q <= slot_valid_d;
            wrap_q       <= wrap_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        b_inc  = b_q + NCH'(1);
        toggle = to_gray(b_inc) ^ to_gray(b_q);
        toggle_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (toggle[i]) toggle_idx = CW'(i);
        end

        state_d      = state_q;
        b_d          = b_q;
        pre_d        = pre_q;
        grant_d      = '0;
        slot_ch_d    = '0;
        slot_valid_d = 1'b0;
        wrap_d       = 1'b0;
        issue        = 1'b0;

        // Capture stage: always one cycle behind the slot; masked slots keep dout.
        dout_valid_d = slot_valid_q;
        dout_ch_d    = slot_ch_q;
        dout_d       = slot_valid_q ? bus.din : dout_q;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = PRE;
                    b_d     = '0;
                    pre_d   = '0;
                end
            end
            PRE: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (pre_q == PW'(PRE_LEN - 1)) begin
                    // The edge that ends the preamble already issues slot 0.
                    state_d = RUN;
                    issue   = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            RUN: begin
                issue = 1'b1;
                if (!bus.en) state_d = DRAIN;
            end
            DRAIN: begin
                // wrap_q marks that the slot on display is the frame's wrap slot,
                // so the stop lands exactly on the frame boundary.
                if (bus.en) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end else if (wrap_q) begin
                    state_d = IDLE;
                end else begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            b_d          = b_inc;
            grant_d      = toggle & bus.ch_mask;
            slot_ch_d    = toggle_idx;
            slot_valid_d = |(toggle & bus.ch_mask);
            wrap_d       = &b_q;
        end

        gray_d = to_gray(b_d);
    end

    assign bus.grant      = grant_q;
    assign bus.slot_ch    = slot_ch_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.gray_cnt   = gray_q;
    assign bus.frame_sync = (state_q == PRE);
    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
